// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencer for a synchronous ROM, one in-flight
// request and a two-entry output FIFO with flush on redirect.
module instr_fetch #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0]    rom_q,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0]    out_instr
);

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] p1_pc;
    logic                     p1_valid;
    logic [ADDRESS_WIDTH-1:0] fifo_pc [2];
    logic [DATA_WIDTH-1:0]    fifo_instr [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;
    logic                     pop;
    logic                     issue;
    logic [2:0]               occupancy;

    assign out_valid   = (count != 2'd0);
    assign pop         = out_valid & out_ready;
    // Words that will sit in the FIFO once the in-flight word lands.
    assign occupancy   = {1'b0, count} + {2'b00, p1_valid} - {2'b00, pop};
    assign issue       = ~redirect_valid & (occupancy < 3'd2);
    assign rom_address = fetch_pc;
    assign out_pc      = fifo_pc[rd_ptr];
    assign out_instr   = fifo_instr[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            p1_pc         <= '0;
            p1_valid      <= 1'b0;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~ADDRESS_WIDTH'(3);
            p1_valid <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            p1_valid <= issue;
            if (issue) begin
                p1_pc    <= fetch_pc;
                fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
            end
            if (p1_valid) begin
                fifo_pc[wr_ptr]    <= p1_pc;
                fifo_instr[wr_ptr] <= rom_q;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, p1_valid} - {1'b0, pop};
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8, byte-address width of PC and ROM address.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 rom_address  output  ADDRESS_WIDTH  byte address to synchronous ROM; driven directly from fetch_pc register.
REQ-007 rom_q  input  DATA_WIDTH  ROM read data; valid in the cycle after rom_address is sampled.
REQ-008 redirect_valid  input  1  flush and restart fetch at redirect_pc.
REQ-009 redirect_pc  input  ADDRESS_WIDTH  redirect target; bits [1:0] ignored (treated as 0).
REQ-010 out_valid  output  1  out_pc/out_instr hold a fetched instruction.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-012 out_pc  output  ADDRESS_WIDTH  byte address of out_instr.
REQ-013 out_instr  output  DATA_WIDTH  instruction word.

Function
REQ-014 State: fetch_pc register, one in-flight stage (p1_valid, p1_pc), 2-entry output FIFO of {pc, instr} with count 0..2.
REQ-015 pop = out_valid & out_ready; issue = ~redirect_valid & ((count + p1_valid - pop) < 2).
REQ-016 On issue: p1_valid <= 1, p1_pc <= fetch_pc, fetch_pc <= fetch_pc + 4, modulo 2^ADDRESS_WIDTH (wrap, no flag).
REQ-017 No issue: p1_valid <= 0, fetch_pc held.
REQ-018 When p1_valid, FIFO write {p1_pc, rom_q} at that cycle's rising edge.
REQ-019 Latency: request issued in cycle t; out_valid high in cycle t+2 if FIFO was empty.
REQ-020 Throughput: one instruction per cycle while out_ready stays high.
REQ-021 out_valid = (count != 0); out_pc/out_instr = FIFO head; all stable while out_valid & ~out_ready.
REQ-022 Simultaneous write and pop: both occur, count unchanged, order preserved.
REQ-023 FIFO never overflows; issue condition guarantees space for the in-flight word.
REQ-024 Redirect (cycle r): handshake in cycle r completes; at edge: FIFO count <= 0, p1_valid <= 0 (in-flight word discarded), fetch_pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}, no issue.
REQ-025 After redirect in cycle r: rom_address = target in cycle r+1; first target out_valid in cycle r+3.
REQ-026 Back-to-back redirects: latest wins; no pre-redirect instruction ever appears on the output.
REQ-027 rom_address changes only at rising edges (no combinational path from inputs).

Reset
REQ-028 While reset high: fetch_pc = RESET_PC, rom_address = RESET_PC, p1_valid = 0, count = 0, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-029 Reset asserted mid-stream: in-flight and buffered words discarded; after release, fetch restarts at RESET_PC per REQ-019.
REQ-030 First issue in first cycle after reset release (cycle 0); out_valid high in cycle 2.

Verification
REQ-031 ROM word at byte address a = a>>2, out_ready=1, reset release -> out_valid from cycle 2; out_pc 0x00,0x04,0x08... one per cycle; out_instr = out_pc>>2.
REQ-032 Backpressure: out_ready low 5 cycles during stream -> out_pc/out_instr frozen, count saturates at 2, rom_address stops advancing; on release no gap, no duplicate, no loss.
REQ-033 Redirect to 0x43 during stream -> next accepted out_pc = 0x40, 3 cycles after redirect cycle; no stale pc accepted after redirect cycle.
REQ-034 Wrap: redirect to 0xF8, ADDRESS_WIDTH=8 -> out_pc sequence 0xF8, 0xFC, 0x00, 0x04.
REQ-035 Reset pulsed mid-stream with FIFO full -> out_valid 0 immediately; restart at RESET_PC, first out_valid 2 cycles after release.
REQ-036 Random out_ready (50%) over 200 cycles -> accepted out_pc strictly sequential +4, out_instr matches ROM model.
